// File: rtl/reg_rename_file.sv
// Architectural integer register file with rename status (busy bit + ROB tag) per register.
// Latency: reads/commit queries are combinational from registered state; writes visible next cycle.
// Backpressure: none; rdy=0 freezes all state while outputs keep reflecting the current state.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (overrides rdy)
//   rdy, clear           global enable; mispredict flush of all busy bits (values/tags kept)
//   commit_*             ROB commit write and busy-clear; commit_busy_q/commit_tag_q answer the
//                        ROB's same-cycle query on commit_rd
//   issue_*              rename allocation (busy set + tag write) for issue_rd
//   rs1_*/rs2_*          operand lookups: value, busy, producing tag
//   busy_cnt             number of registers currently busy
// Optional build macro: REG_COMMIT_BYPASS_EN forwards a same-cycle commit to the read ports.
module reg_rename_file #(
    parameter int NREG   = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clear,
    input  logic                     commit_en,
    input  logic [$clog2(NREG)-1:0]  commit_rd,
    input  logic [DATA_W-1:0]        commit_value,
    input  logic                     commit_clr,
    output logic                     commit_busy_q,
    output logic [TAG_W-1:0]         commit_tag_q,
    input  logic                     issue_en,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic [$clog2(NREG)-1:0]  rs1_idx,
    input  logic [$clog2(NREG)-1:0]  rs2_idx,
    output logic [DATA_W-1:0]        rs1_value,
    output logic [DATA_W-1:0]        rs2_value,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [TAG_W-1:0]         rs1_tag,
    output logic [TAG_W-1:0]         rs2_tag,
    output logic [5:0]               busy_cnt
);

    logic [DATA_W-1:0] value_q [NREG];
    logic [TAG_W-1:0]  tag_q   [NREG];
    logic [NREG-1:0]   busy_q;
    logic [5:0]        busy_cnt_q;

    logic [NREG-1:0]   busy_nxt;
    logic [5:0]        cnt_nxt;
    logic              cmt_wr;
    logic              cmt_clr;
    logic              iss_set;
    logic              same_rd;
    logic              cnt_inc;
    logic              cnt_dec;

    // Register 0 is never written, so its state stays at the reset value of zero.
    assign cmt_wr  = rdy && commit_en && (commit_rd != '0);
    assign cmt_clr = cmt_wr && commit_clr;
    assign iss_set = rdy && issue_en && (issue_rd != '0) && !clear;
    assign same_rd = iss_set && (issue_rd == commit_rd);

    // A same-rd issue overrides the commit's busy clear, so that commit must not decrement.
    assign cnt_inc = iss_set && !busy_q[issue_rd];
    assign cnt_dec = cmt_clr && busy_q[commit_rd] && !same_rd;

    always_comb begin
        busy_nxt = busy_q;
        cnt_nxt  = busy_cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
        if (cmt_clr) busy_nxt[commit_rd] = 1'b0;
        if (iss_set) busy_nxt[issue_rd]  = 1'b1;
        if (clear) begin
            busy_nxt = '0;
            cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else if (rdy) begin
            if (cmt_wr)  value_q[commit_rd] <= commit_value;
            if (iss_set) tag_q[issue_rd]    <= issue_tag;
            busy_q     <= busy_nxt;
            busy_cnt_q <= cnt_nxt;
        end
    end

    assign commit_busy_q = busy_q[commit_rd];
    assign commit_tag_q  = tag_q[commit_rd];
    assign busy_cnt      = busy_cnt_q;

    always_comb begin
        rs1_value = value_q[rs1_idx];
        rs1_busy  = busy_q[rs1_idx];
        rs1_tag   = tag_q[rs1_idx];
        rs2_value = value_q[rs2_idx];
        rs2_busy  = busy_q[rs2_idx];
        rs2_tag   = tag_q[rs2_idx];
`ifdef REG_COMMIT_BYPASS_EN
        // Forward the in-flight commit; the tag is left alone since commits never change it.
        if (cmt_wr && (rs1_idx == commit_rd)) begin
            rs1_value = commit_value;
            if (commit_clr && !same_rd) rs1_busy = 1'b0;
        end
        if (cmt_wr && (rs2_idx == commit_rd)) begin
            rs2_value = commit_value;
            if (commit_clr && !same_rd) rs2_busy = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: vector table with scoreboard queue plus
// hand-written sequences for reset, same-cycle commit forwarding and reset-over-rdy.
module tb_reg_rename_file;

    logic        clk, rst, rdy, clear;
    logic        commit_en, commit_clr, commit_busy_q;
    logic [4:0]  commit_rd, issue_rd, rs1_idx, rs2_idx;
    logic [31:0] commit_value, rs1_value, rs2_value;
    logic [3:0]  commit_tag_q, issue_tag, rs1_tag, rs2_tag;
    logic        issue_en, rs1_busy, rs2_busy;
    logic [5:0]  busy_cnt;

    reg_rename_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_clr(commit_clr), .commit_busy_q(commit_busy_q), .commit_tag_q(commit_tag_q),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ie; logic [4:0] ird; logic [3:0] itag;
        logic ce; logic [4:0] crd; logic [31:0] cval; logic ccl;
        logic clr; logic rdy; logic [4:0] r1; logic [4:0] r2;
        logic [31:0] e1v; logic e1b; logic [3:0] e1t;
        logic [31:0] e2v; logic e2b; logic [3:0] e2t;
        logic [5:0] ecnt; logic ecb; logic [3:0] ect;
    } vec_t;

    typedef struct {
        logic [31:0] r1v; logic r1b; logic [3:0] r1t;
        logic [31:0] r2v; logic r2b; logic [3:0] r2t;
        logic [5:0] cnt; logic cb; logic [3:0] ct;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    task automatic idle();
        issue_en = 1'b0; commit_en = 1'b0; commit_clr = 1'b0;
        clear = 1'b0; rdy = 1'b1;
    endtask

    task automatic apply(int n, vec_t v);
        exp_t e;
        issue_en = v.ie; issue_rd = v.ird; issue_tag = v.itag;
        commit_en = v.ce; commit_rd = v.crd; commit_value = v.cval; commit_clr = v.ccl;
        clear = v.clr; rdy = v.rdy; rs1_idx = v.r1; rs2_idx = v.r2;
        sb.push_back('{v.e1v, v.e1b, v.e1t, v.e2v, v.e2b, v.e2t, v.ecnt, v.ecb, v.ect});
        @(posedge clk);
        #1 idle();
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d.rs1_value", n), rs1_value, e.r1v);
        chk($sformatf("v%0d.rs1_busy",  n), 32'(rs1_busy), 32'(e.r1b));
        chk($sformatf("v%0d.rs1_tag",   n), 32'(rs1_tag),  32'(e.r1t));
        chk($sformatf("v%0d.rs2_value", n), rs2_value, e.r2v);
        chk($sformatf("v%0d.rs2_busy",  n), 32'(rs2_busy), 32'(e.r2b));
        chk($sformatf("v%0d.rs2_tag",   n), 32'(rs2_tag),  32'(e.r2t));
        chk($sformatf("v%0d.busy_cnt",  n), 32'(busy_cnt), 32'(e.cnt));
        chk($sformatf("v%0d.commit_busy_q", n), 32'(commit_busy_q), 32'(e.cb));
        chk($sformatf("v%0d.commit_tag_q",  n), 32'(commit_tag_q),  32'(e.ct));
    endtask

    vec_t vecs [15];

    initial begin
        //          ie ird itag ce crd cval          ccl clr rdy r1 r2  e1v           e1b e1t e2v           e2b e2t cnt cb ct
        vecs[0]  = '{1, 3, 7,   0, 3, 32'h0,        0, 0, 1,  3, 0, 32'h0,        1, 7,  32'h0,        0, 0,  1, 1, 7};
        vecs[1]  = '{0, 0, 0,   1, 3, 32'hDEADBEEF, 1, 0, 1,  3, 0, 32'hDEADBEEF, 0, 7,  32'h0,        0, 0,  0, 0, 7};
        vecs[2]  = '{1, 4, 2,   0, 4, 32'h0,        0, 0, 1,  4, 0, 32'h0,        1, 2,  32'h0,        0, 0,  1, 1, 2};
        vecs[3]  = '{1, 4, 9,   1, 4, 32'h11,       1, 0, 1,  4, 0, 32'h11,       1, 9,  32'h0,        0, 0,  1, 1, 9};
        vecs[4]  = '{0, 0, 0,   1, 4, 32'h11,       1, 0, 1,  4, 0, 32'h11,       0, 9,  32'h0,        0, 0,  0, 0, 9};
        vecs[5]  = '{1, 0, 5,   1, 0, 32'hFF,       1, 0, 1,  0, 4, 32'h0,        0, 0,  32'h11,       0, 9,  0, 0, 0};
        vecs[6]  = '{1, 1, 1,   0, 1, 32'h0,        0, 0, 1,  1, 0, 32'h0,        1, 1,  32'h0,        0, 0,  1, 1, 1};
        vecs[7]  = '{1, 2, 2,   0, 2, 32'h0,        0, 0, 1,  2, 0, 32'h0,        1, 2,  32'h0,        0, 0,  2, 1, 2};
        vecs[8]  = '{1, 3, 3,   0, 3, 32'h0,        0, 0, 1,  3, 1, 32'hDEADBEEF, 1, 3,  32'h0,        1, 1,  3, 1, 3};
        vecs[9]  = '{1, 5, 6,   1, 1, 32'h42,       0, 1, 1,  1, 5, 32'h42,       0, 1,  32'h0,        0, 0,  0, 0, 1};
        vecs[10] = '{1, 6, 4,   1, 7, 32'h77,       1, 0, 0,  6, 7, 32'h0,        0, 0,  32'h0,        0, 0,  0, 0, 0};
        vecs[11] = '{1, 6, 4,   0, 6, 32'h0,        0, 0, 1,  6, 3, 32'h0,        1, 4,  32'hDEADBEEF, 0, 3,  1, 1, 4};
        vecs[12] = '{0, 0, 0,   1, 6, 32'h66,       0, 0, 1,  6, 0, 32'h66,       1, 4,  32'h0,        0, 0,  1, 1, 4};
        vecs[13] = '{0, 0, 0,   1, 6, 32'h60,       1, 0, 1,  6, 0, 32'h60,       0, 4,  32'h0,        0, 0,  0, 0, 4};
        vecs[14] = '{0, 0, 0,   1, 6, 32'h61,       1, 0, 1,  6, 0, 32'h61,       0, 4,  32'h0,        0, 0,  0, 0, 4};

        rst = 1'b1; idle();
        issue_rd = '0; issue_tag = '0; commit_rd = 5'd5; commit_value = '0;
        rs1_idx = 5'd5; rs2_idx = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset.rs1_value", rs1_value, 32'h0);
        chk("reset.rs1_busy", 32'(rs1_busy), 32'h0);
        chk("reset.rs1_tag", 32'(rs1_tag), 32'h0);
        chk("reset.rs2_value", rs2_value, 32'h0);
        chk("reset.busy_cnt", 32'(busy_cnt), 32'h0);
        chk("reset.commit_busy_q", 32'(commit_busy_q), 32'h0);

        for (int i = 0; i < 15; i++) apply(i, vecs[i]);

        // Same-cycle commit to a busy register while rs2 looks it up.
        issue_en = 1'b1; issue_rd = 5'd8; issue_tag = 4'd10;
        @(posedge clk);
        #1 idle();
        rs2_idx = 5'd8;
        commit_en = 1'b1; commit_rd = 5'd8; commit_value = 32'h55; commit_clr = 1'b1;
        #1;
`ifdef REG_COMMIT_BYPASS_EN
        chk("bypass.rs2_value", rs2_value, 32'h55);
        chk("bypass.rs2_busy", 32'(rs2_busy), 32'h0);
`else
        chk("nobypass.rs2_value", rs2_value, 32'h0);
        chk("nobypass.rs2_busy", 32'(rs2_busy), 32'h1);
`endif
        chk("samecycle.rs2_tag", 32'(rs2_tag), 32'd10);
        chk("samecycle.busy_cnt", 32'(busy_cnt), 32'd1);
        @(posedge clk);
        #1 idle();
        #1;
        chk("aftercommit.rs2_value", rs2_value, 32'h55);
        chk("aftercommit.rs2_busy", 32'(rs2_busy), 32'h0);
        chk("aftercommit.rs2_tag", 32'(rs2_tag), 32'd10);
        chk("aftercommit.busy_cnt", 32'(busy_cnt), 32'd0);

        // Reset must win even while rdy is low.
        issue_en = 1'b1; issue_rd = 5'd9; issue_tag = 4'd3;
        @(posedge clk);
        #1 idle();
        rst = 1'b1; rdy = 1'b0; rs1_idx = 5'd6; rs2_idx = 5'd9;
        @(posedge clk);
        #1 rst = 1'b0; rdy = 1'b1;
        #1;
        chk("rst_over_rdy.rs1_value", rs1_value, 32'h0);
        chk("rst_over_rdy.rs1_tag", 32'(rs1_tag), 32'h0);
        chk("rst_over_rdy.rs2_busy", 32'(rs2_busy), 32'h0);
        chk("rst_over_rdy.busy_cnt", 32'(busy_cnt), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
